// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and reader state encoding for the 128-bit FIFO path
package fifo_pkg;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;
endpackage

// File: rtl/fifo_stream_reader_128_skid.sv
// rtl/fifo_stream_reader_128_skid.sv - 2-entry in-order buffer between FIFO capture and the output stream
module skid_buf_2 import fifo_pkg::*; #(
  parameter int DATA_W = fifo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic              valid,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occ
);
  logic [DATA_W-1:0] tail_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      tail_data <= '0;
      occ       <= 2'd0;
    end else if (clear) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head_data <= push_data;
          else             tail_data <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          // occ is unchanged; the capture lands behind the new head
          if (occ == 2'd2) head_data <= tail_data;
          else             head_data <= push_data;
          tail_data <= push_data;
        end
        default: ;
      endcase
    end
  end

  assign valid = (occ != 2'd0);
endmodule

// File: rtl/fifo_stream_reader_128.sv
// rtl/fifo_stream_reader_128.sv - FIFO read engine: pops, captures and streams words, with flush and counters
module fifo_stream_reader_128 import fifo_pkg::*; #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_en_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              busy_o,
  output logic              flush_done_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);
  rd_state_e  state, state_nx;
  logic       pend;
  logic [1:0] occ;
  logic       pop, push, flush_enter;
  logic [2:0] fill;
  logic [1:0] drop_inc;

  skid_buf_2 #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_data_i),
    .pop       (pop),
    .clear     (flush_enter),
    .valid     (m_valid_o),
    .head_data (m_data_o),
    .occ       (occ)
  );

  assign pop         = m_valid_o & m_ready_i;
  assign flush_enter = flush_i && (state != FLUSH);
  // the in-flight word is discarded, not captured, on the flush entry edge
  assign push        = pend && (state != FLUSH) && !flush_enter;
  assign fill        = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
  assign busy_o      = (state != IDLE) || pend || (occ != 2'd0);

  always_comb begin
    state_nx     = state;
    fifo_rd_en_o = 1'b0;
    flush_done_o = 1'b0;
    drop_inc     = 2'd0;
    case (state)
      IDLE: begin
        if (flush_i) begin
          state_nx = FLUSH;
          drop_inc = occ - {1'b0, pop} + {1'b0, pend};
        end else if (en_i) begin
          state_nx = STREAM;
        end
      end
      STREAM: begin
        fifo_rd_en_o = en_i && !fifo_empty_i && (fill < 3'd2);
        if (flush_i) begin
          state_nx = FLUSH;
          drop_inc = occ - {1'b0, pop} + {1'b0, pend};
        end else if (!en_i) begin
          state_nx = IDLE;
        end
      end
      FLUSH: begin
        fifo_rd_en_o = !fifo_empty_i;
        drop_inc     = {1'b0, pend};
        if (fifo_empty_i && !pend) begin
          state_nx     = IDLE;
          flush_done_o = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend       <= 1'b0;
      beat_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      state      <= state_nx;
      pend       <= fifo_rd_en_o & !fifo_empty_i;
      beat_cnt_o <= beat_cnt_o + CNT_W'(pop);
      drop_cnt_o <= drop_cnt_o + CNT_W'(drop_inc);
    end
  end
endmodule

// File: doc/fifo_stream_reader_128.md
Name: fifo_stream_reader_128

Overview:
Read-side engine for the 128-bit FIFO. It issues pops to the FIFO and captures the registered read data one cycle later. It re-presents that data as a valid/ready stream to the downstream consumer, which is the decrypt/output stage. It also provides a flush mode that drains and discards FIFO contents, plus delivered and dropped word counters.

Parameters:
DATA_W, 128, stream/FIFO word width
CNT_W, 16, width of beat and drop counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en_i  in  1  1 = stream FIFO words downstream
flush_i  in  1  single-cycle request to discard buffered and FIFO contents
fifo_empty_i  in  1  FIFO empty flag
fifo_data_i  in  DATA_W  FIFO read data; updates the cycle after an accepted pop
fifo_rd_en_o  out  1  FIFO pop request
m_valid_o  out  1  output word valid
m_ready_i  in  1  downstream accept
m_data_o  out  DATA_W  output word
busy_o  out  1  state != IDLE, or a pop is pending, or the buffer is non-empty
flush_done_o  out  1  one-cycle pulse when a flush completes
beat_cnt_o  out  CNT_W  words delivered (m_valid_o & m_ready_i); wraps
drop_cnt_o  out  CNT_W  words discarded by flush; wraps

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; pend=0; occ=0.
  - All outputs 0; buffer data registers 0.
- FIFO contract:
  - A pop is accepted when fifo_rd_en_o=1 and fifo_empty_i=0 in the same cycle.
  - Accepted pop sets pend=1; the word is sampled from fifo_data_i on the next edge.
  - fifo_rd_en_o while empty is harmless but is never counted.
- Internal buffer:
  - 2-entry FIFO (skid), occ in 0..2; m_data_o = head entry; m_valid_o = (occ != 0).
  - Data is held stable while m_valid_o=1 and m_ready_i=0.
- States: IDLE, STREAM, FLUSH.
  - IDLE -> STREAM when en_i=1.
  - STREAM -> IDLE when en_i=0. No new pops are issued; a pending word is still captured; the buffer keeps draining.
  - IDLE/STREAM -> FLUSH on flush_i=1, which has priority over en_i.
  - FLUSH -> IDLE on the cycle fifo_empty_i=1 and pend=0; flush_done_o=1 for that one cycle. Next cycle re-evaluates en_i.
- STREAM pop rule (combinational):
  - fifo_rd_en_o = !fifo_empty_i && (occ + pend - pop) < 2, where pop = m_valid_o & m_ready_i.
  - This sustains 1 word/cycle with m_ready_i held high.
  - The buffer can never overflow.
- FLUSH behaviour:
  - On entry edge: occ<=0, which drops m_valid_o.
  - A pend word in flight, and every subsequent popped word, is discarded and increments drop_cnt_o.
  - Buffered words discarded on entry also count: drop_cnt_o += occ.
  - fifo_rd_en_o = !fifo_empty_i every cycle.
  - m_valid_o=0 throughout FLUSH.
  - flush_i while already in FLUSH is ignored.
- Simultaneous pop and capture in the same cycle: occ unchanged and order preserved. The capture is written behind the head, or becomes the head if occ becomes 0.
- Counters: beat_cnt_o increments once per handshake; both counters wrap modulo 2^CNT_W with no saturation.
- Latency: FIFO non-empty -> fifo_rd_en_o same cycle -> m_valid_o 2 cycles after the pop cycle (FIFO register + capture register).
- Reset mid-operation:
  - Everything clears asynchronously.
  - A FIFO word popped in the reset cycle is lost. This is the system's responsibility; both blocks share rst_n.

Decomposition:
- Shared package (fifo_pkg):
  - DATA_W=128, FIFO DEPTH=8.
  - State encoding localparams: IDLE=2'd0, STREAM=2'd1, FLUSH=2'd2.
- One natural sub-module: skid_buf_2 (2-entry valid/ready buffer with push/pop/clear, occ output). The reader FSM and counters stay in the top.

Test Plan:
1. FIFO preloaded with 3 words A0..A2, en_i=1, m_ready_i=1 -> rd_en high 3 consecutive cycles; m_data_o = A0, A1, A2 on consecutive cycles; beat_cnt_o=3; busy_o returns to 0.
2. Backpressure: 8 words queued, m_ready_i=0 -> exactly 2 pops accepted, occ=2, m_data_o stable = word0. Then m_ready_i=1 -> all 8 words delivered in order, none lost or duplicated.
3. Flush: 5 words in FIFO, 2 in buffer, flush_i pulse -> m_valid_o=0 next cycle; FIFO drained; flush_done_o pulses once; drop_cnt_o=7; beat_cnt_o unchanged.
4. en_i dropped the cycle after a pop -> that pending word is still delivered; no further fifo_rd_en_o; state=IDLE.
5. flush_i and en_i rising in the same cycle from IDLE with empty FIFO -> FLUSH for 1 cycle; flush_done_o=1; drop_cnt_o=0; then STREAM.
6. Async reset asserted with occ=2, pend=1 -> all outputs 0 immediately; after release, a 1-word stream passes normally with beat_cnt_o=1.
